// File: rtl/snn_pkg.sv
// Shared definitions for the SNN inference controller: FSM state encoding and
// default configuration constants.
package snn_pkg;

   localparam int unsigned DEF_NUM_CLASSES = 3;
   localparam int unsigned DEF_NUM_STEPS   = 32;
   localparam int unsigned DEF_CLR_CYCLES  = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DECIDE
   } state_e;

endpackage

// File: rtl/snn_argmax.sv
// Combinational argmax over per-class spike counts; lowest index wins ties,
// with tie and all-zero (silent) flags. A silent result reports index 0, no tie.
module snn_argmax #(
   parameter int unsigned N     = 3,
   parameter int unsigned W     = 8,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0][W-1:0] cnt,
   output logic [IDX_W-1:0]    idx,
   output logic                tie,
   output logic                silent
);

   logic [W-1:0] max_v;
   int unsigned  n_max;

   always_comb begin
      max_v = cnt[0];
      idx   = '0;
      n_max = 0;
      // strict '>' keeps the earliest index on equal counts
      for (int unsigned i = 1; i < N; i++) begin
         if (cnt[i] > max_v) begin
            max_v = cnt[i];
            idx   = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (cnt[i] == max_v) n_max++;
      end
      silent = (max_v == '0);
      tie    = !silent && (n_max > 1);
   end

endmodule

// File: rtl/snn_infer_ctrl.sv
// SNN inference controller: clears the neuron array, counts output spikes over
// NUM_STEPS timesteps and reports the winning class. Optional run watchdog
// enabled by defining SNN_INFER_CTRL_WATCHDOG_EN.
module snn_infer_ctrl
   import snn_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int unsigned NUM_STEPS   = DEF_NUM_STEPS,
   parameter int unsigned STEP_W      = 8,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned CLR_CYCLES  = DEF_CLR_CYCLES
`ifdef SNN_INFER_CTRL_WATCHDOG_EN
  ,parameter int unsigned WDOG_CYCLES = 1024
`endif
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   output logic                           busy_o,
   output logic                           net_clr_o,
   input  logic                           next_stage_i,
   input  logic [NUM_CLASSES-1:0]         spike_i,
   output logic                           done_o,
   output logic [$clog2(NUM_CLASSES)-1:0] class_o,
   output logic                           tie_o,
   output logic                           silent_o
`ifdef SNN_INFER_CTRL_WATCHDOG_EN
  ,output logic                           timeout_o
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_CLASSES);
   localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

   state_e                         state_q, state_d;
   logic [CLR_W-1:0]               clr_cnt_q;
   logic [STEP_W-1:0]              step_q;
   logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0]               am_idx, class_q;
   logic                           am_tie, am_silent, tie_q, silent_q, done_q;
   logic                           start_ok, clr_last, step_last, wd_fire;

   // start on the done cycle is dropped, not queued
   assign start_ok  = start_i && !done_q;
   assign clr_last  = (clr_cnt_q == CLR_W'(CLR_CYCLES - 1));
   assign step_last = next_stage_i && (step_q == STEP_W'(NUM_STEPS - 1));

   snn_argmax #(
      .N     (NUM_CLASSES),
      .W     (CNT_W),
      .IDX_W (IDX_W)
   ) u_argmax (
      .cnt    (cnt_q),
      .idx    (am_idx),
      .tie    (am_tie),
      .silent (am_silent)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      busy_o    = (state_q != S_IDLE);
      net_clr_o = (state_q == S_CLEAR);
      unique case (state_q)
         S_IDLE:   if (start_ok) state_d = S_CLEAR;
         S_CLEAR:  if (clr_last) state_d = S_RUN;
         S_RUN: begin
            if (step_last)    state_d = S_DECIDE;
            else if (wd_fire) state_d = S_IDLE;
         end
         S_DECIDE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         clr_cnt_q <= '0;
         step_q    <= '0;
         cnt_q     <= '0;
         class_q   <= '0;
         tie_q     <= 1'b0;
         silent_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  clr_cnt_q <= '0;
                  step_q    <= '0;
                  cnt_q     <= '0;
               end
            end
            S_CLEAR: clr_cnt_q <= clr_cnt_q + 1'b1;
            S_RUN: begin
               for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                  if (spike_i[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
               end
               if (next_stage_i) step_q <= step_q + 1'b1;
            end
            S_DECIDE: begin
               class_q  <= am_idx;
               tie_q    <= am_tie;
               silent_q <= am_silent;
               done_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SNN_INFER_CTRL_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

   logic [WD_W-1:0] wd_q;
   logic            timeout_q;

   assign wd_fire = (state_q == S_RUN) && !next_stage_i && (wd_q == WD_W'(WDOG_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wd_fire;
         if ((state_q != S_RUN) || next_stage_i) wd_q <= '0;
         else                                    wd_q <= wd_q + 1'b1;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign wd_fire = 1'b0;
`endif

   assign done_o   = done_q;
   assign class_o  = class_q;
   assign tie_o    = tie_q;
   assign silent_o = silent_q;

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Directed self-checking bench for snn_infer_ctrl (NUM_STEPS=4, CLR_CYCLES=2,
// CNT_W=4); covers the watchdog when SNN_INFER_CTRL_WATCHDOG_EN is defined.
module tb_snn_infer_ctrl;

   localparam int unsigned NC  = 3;
   localparam int unsigned NS  = 4;
   localparam int unsigned CLR = 2;
   localparam int unsigned CW  = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i = 1'b0;
   logic          next_stage_i = 1'b0;
   logic [NC-1:0] spike_i = '0;
   logic          busy_o, net_clr_o, done_o, tie_o, silent_o;
   logic [1:0]    class_o;
`ifdef SNN_INFER_CTRL_WATCHDOG_EN
   logic          timeout_o;
`endif

   int n_tests = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, clr_cnt = 0;
   int to_cnt = 0, to_cyc = 0, to_busy = 0;

   snn_infer_ctrl #(
      .NUM_CLASSES (NC),
      .NUM_STEPS   (NS),
      .STEP_W      (8),
      .CNT_W       (CW),
      .CLR_CYCLES  (CLR)
`ifdef SNN_INFER_CTRL_WATCHDOG_EN
     ,.WDOG_CYCLES (16)
`endif
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .busy_o       (busy_o),
      .net_clr_o    (net_clr_o),
      .next_stage_i (next_stage_i),
      .spike_i      (spike_i),
      .done_o       (done_o),
      .class_o      (class_o),
      .tie_o        (tie_o),
      .silent_o     (silent_o)
`ifdef SNN_INFER_CTRL_WATCHDOG_EN
     ,.timeout_o    (timeout_o)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_o) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (net_clr_o) clr_cnt <= clr_cnt + 1;
`ifdef SNN_INFER_CTRL_WATCHDOG_EN
      if (timeout_o) begin
         to_cnt  <= to_cnt + 1;
         to_cyc  <= cyc;
         to_busy <= int'(busy_o);
      end
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full inference: NS step pulses every 'gap' RUN cycles. The first n_spk
   // step cycles carry s_step; other RUN cycles carry s_other. 'noise' drives
   // spikes/steps during CLEAR, 'inj' drives start during RUN, and start is
   // always driven on the done cycle.
   task automatic run_inf(input string tag, input int gap, input logic [2:0] s_step,
                          input int n_spk, input logic [2:0] s_other, input bit noise,
                          input bit inj, input logic [1:0] e_cls, input bit e_tie,
                          input bit e_sil);
      int d0, c0, t0;
      d0 = done_cnt;
      c0 = clr_cnt;
      start_i = 1'b1;
      t0 = cyc;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < int'(CLR); c++) begin
         next_stage_i = noise;
         spike_i      = noise ? 3'b111 : 3'b000;
         tick();
      end
      for (int p = 0; p < int'(NS); p++) begin
         for (int j = 1; j <= gap; j++) begin
            next_stage_i = (j == gap);
            spike_i      = (j == gap) ? ((p < n_spk) ? s_step : 3'b000) : s_other;
            start_i      = inj;
            tick();
         end
      end
      next_stage_i = 1'b0;
      spike_i      = '0;
      start_i      = 1'b0;
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      @(negedge clk);
      check({tag, "/done_count"}, done_cnt - d0, 1);
      check({tag, "/clr_cycles"}, clr_cnt - c0, CLR);
      check({tag, "/latency"}, done_cyc - t0, 1 + CLR + gap * NS + 1);
      check({tag, "/busy_after_done_start"}, busy_o, 0);
      check({tag, "/class"}, class_o, e_cls);
      check({tag, "/tie"}, tie_o, e_tie);
      check({tag, "/silent"}, silent_o, e_sil);
   endtask

   initial begin
      int d0;
      #12;
      check("rst/busy", busy_o, 0);
      check("rst/net_clr", net_clr_o, 0);
      check("rst/done", done_o, 0);
      check("rst/class", class_o, 0);
      check("rst/tie", tie_o, 0);
      check("rst/silent", silent_o, 0);
      tick();
      rst_i = 1'b1;
      tick();

      run_inf("basic",    3, 3'b010, 4, 3'b000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
      run_inf("tie02",    2, 3'b101, 3, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      run_inf("silent",   3, 3'b000, 0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      run_inf("sat",     10, 3'b001, 4, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      check("sat/counter0", 32'(dut.cnt_q[0]), 15);
      run_inf("sat_tie", 10, 3'b101, 4, 3'b101, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      run_inf("tie12",    1, 3'b110, 4, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);

      // abort a run mid-RUN with heavy class-0 activity
      d0 = done_cnt;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < int'(CLR); c++) tick();
      for (int j = 1; j <= 6; j++) begin
         next_stage_i = (j % 3 == 0);
         spike_i      = 3'b001;
         tick();
      end
      next_stage_i = 1'b0;
      spike_i      = '0;
      rst_i        = 1'b0;
      #2;
      check("abort/busy", busy_o, 0);
      check("abort/class", class_o, 0);
      check("abort/tie", tie_o, 0);
      check("abort/net_clr", net_clr_o, 0);
      tick();
      rst_i = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("abort/no_done", done_cnt - d0, 0);
      check("abort/counter0", 32'(dut.cnt_q[0]), 0);
      tick();
      run_inf("after_abort", 1, 3'b010, 4, 3'b000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);

`ifdef SNN_INFER_CTRL_WATCHDOG_EN
      begin
         int pc, t0c, waited;
         d0  = done_cnt;
         t0c = to_cnt;
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
         for (int c = 0; c < int'(CLR); c++) tick();
         next_stage_i = 1'b1;
         spike_i      = 3'b100;
         pc = cyc;
         tick();
         next_stage_i = 1'b0;
         spike_i      = '0;
         waited = 0;
         while (to_cnt == t0c && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         check("wdog/fired", to_cnt - t0c, 1);
         check("wdog/delay", to_cyc - pc, 17);
         check("wdog/busy", to_busy, 0);
         tick();
         tick();
         @(negedge clk);
         check("wdog/no_done", done_cnt - d0, 0);
         check("wdog/class_held", class_o, 1);
         check("wdog/idle", busy_o, 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/snn_infer_ctrl.md
SNN_INFER_CTRL -- requirements
Module: snn_infer_ctrl

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 3, number of output neurons scored.
REQ-002 SHALL have parameter NUM_STEPS, default 32, timesteps per inference (valid range 1..2^STEP_W-1).
REQ-003 SHALL have parameter STEP_W, default 8, width of step counter.
REQ-004 SHALL have parameter CNT_W, default 8, width of per-class spike counters.
REQ-005 SHALL have parameter CLR_CYCLES, default 2, cycles of network clear before each run (valid range >=1).
REQ-006 SHALL have port clk_i, input, 1, sole clock, all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start_i, input, 1, request one inference; sampled only in IDLE.
REQ-009 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-010 SHALL have port net_clr_o, output, 1, active-high clear to the neuron array (membrane/threshold state).
REQ-011 SHALL have port next_stage_i, input, 1, one-cycle pulse from the input delay stage marking one completed timestep.
REQ-012 SHALL have port spike_i, input, NUM_CLASSES, output spikes of the neuron array.
REQ-013 SHALL have port done_o, output, 1, one-cycle pulse when result is valid.
REQ-014 SHALL have port class_o, output, $clog2(NUM_CLASSES), winning class index.
REQ-015 SHALL have port tie_o, output, 1, max count shared by more than one class.
REQ-016 SHALL have port silent_o, output, 1, all class counts zero.

Function
REQ-017 SHALL implement FSM IDLE -> CLEAR -> RUN -> DECIDE -> IDLE.
REQ-018 IDLE: start_i=1 -> CLEAR next cycle; per-class counters and step counter zeroed on this transition.
REQ-019 CLEAR: net_clr_o=1 for exactly CLR_CYCLES cycles, then RUN; next_stage_i and spike_i ignored in CLEAR.
REQ-020 RUN: each cycle, counter[k] increments when spike_i[k]=1; counters saturate at 2^CNT_W-1 (no wrap).
REQ-021 RUN: step counter increments on next_stage_i=1; spikes on that same cycle are counted.
REQ-022 RUN -> DECIDE on the cycle step counter reaches NUM_STEPS (after the increment).
REQ-023 DECIDE (one cycle): class_o = index of max counter, lowest index wins ties; tie_o, silent_o computed; silent implies class_o=0 and tie_o=0.
REQ-024 done_o pulses one cycle on DECIDE -> IDLE; class_o/tie_o/silent_o registered and held until the next DECIDE.
REQ-025 start_i outside IDLE SHALL be ignored (not queued); start_i on the done_o cycle is ignored.
REQ-026 Latency from start_i to done_o SHALL equal 1 + CLR_CYCLES + (cycles to NUM_STEPS pulses) + 1.

Reset
REQ-027 rst_i=0 SHALL asynchronously force IDLE, busy_o=0, net_clr_o=0, done_o=0, class_o=0, tie_o=0, silent_o=0, all counters 0.
REQ-028 Reset mid-run SHALL discard partial counts; no done_o is produced for the aborted run.

Configuration
REQ-029 Macro SNN_INFER_CTRL_WATCHDOG_EN: when defined, add parameter WDOG_CYCLES (default 1024), output timeout_o; if RUN sees no next_stage_i for WDOG_CYCLES consecutive cycles, FSM SHALL go to IDLE with one-cycle timeout_o pulse, no done_o, results unchanged.
REQ-030 Without SNN_INFER_CTRL_WATCHDOG_EN: no watchdog logic, no timeout_o port; RUN waits indefinitely.

Structure
REQ-031 Shared package snn_pkg SHALL hold the FSM state enum and default parameter constants (NUM_CLASSES, NUM_STEPS, CLR_CYCLES).
REQ-032 Argmax SHALL be a sub-module snn_argmax (combinational, lowest-index tie rule, tie and silent flags); counters and FSM stay in snn_infer_ctrl.

Verification
REQ-033 NUM_STEPS=4, CLR_CYCLES=2, next_stage_i every 3rd cycle, spike_i=3'b010 each step cycle -> done_o once, class_o=1, tie_o=0, silent_o=0, net_clr_o high exactly 2 cycles.
REQ-034 Equal spikes on classes 0 and 2 (3 each) -> class_o=0, tie_o=1.
REQ-035 spike_i=0 throughout -> class_o=0, silent_o=1, tie_o=0.
REQ-036 CNT_W=4, spike_i[0] held high 40 cycles -> counter[0]=15, class_o=0.
REQ-037 rst_i low mid-RUN then new start_i -> no done_o for first run; second run result depends only on second-run spikes; start_i pulses during RUN have no effect.
REQ-038 With SNN_INFER_CTRL_WATCHDOG_EN, WDOG_CYCLES=16, next_stage_i stopped in RUN -> timeout_o after 16 idle cycles, busy_o=0, done_o never asserted.
